// File: rtl/pwm_multi_burst_pkg.sv
// Shared types for the multi-channel burst PWM block.
// Latency: n/a (types, defaults and a decode helper only).
// Backpressure: n/a.
package pwm_multi_burst_pkg;

    localparam int PWM_NUM_CH  = 4;
    localparam int PWM_CNT_W   = 16;
    localparam int PWM_BURST_W = 8;

    typedef enum logic [1:0] {
        MODE_CONT         = 2'd0,
        MODE_BURST_ONCE   = 2'd1,
        MODE_BURST_REPEAT = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Raw code 3 aliases continuous mode.
    function automatic mode_t mode_decode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_BURST_ONCE;
            2'd2:    return MODE_BURST_REPEAT;
            default: return MODE_CONT;
        endcase
    endfunction

endpackage

// File: rtl/pwm_multi_burst_chan.sv
// One PWM channel: pending/active cfg, IDLE/RUN/GAP FSM, cycle and period counters.
// Latency: PWM is registered, one cycle behind the counter state it reflects.
// Backpressure: none; cfg writes always land in the pending registers.
// Ports: cfg_* pending-config write, enable/trig run control, pwm/busy/burst_done status.
module pwm_multi_burst_chan
    import pwm_multi_burst_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int BURST_W = PWM_BURST_W
) (
    input  logic               SysClk,
    input  logic               Reset,
    input  logic               cfg_wr,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [1:0]         cfg_mode,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [BURST_W-1:0] cfg_gap,
    input  logic               enable,
    input  logic               trig,
    output logic               pwm,
    output logic               busy,
    output logic               burst_done
);

    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   high;
        mode_t              mode;
        logic [BURST_W-1:0] burst;
        logic [BURST_W-1:0] gap;
    } cfg_t;

    cfg_t               pend_q, act_q, act_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] per_q, per_d;
    logic               pwm_d, done_d;
    logic               wrap, per_last_burst, per_last_gap;
    logic [BURST_W-1:0] burst_len;
    logic [BURST_W:0]   per_inc;

    // A zero burst length behaves as a single period.
    assign burst_len      = (act_q.burst == '0) ? BURST_W'(1) : act_q.burst;
    assign per_inc        = {1'b0, per_q} + (BURST_W+1)'(1);
    // >= rather than == so a shortened B or G committed mid-burst still terminates.
    assign per_last_burst = per_inc >= {1'b0, burst_len};
    assign per_last_gap   = per_inc >= {1'b0, act_q.gap};
    assign wrap           = (state_q != ST_IDLE) && (act_q.period != '0) &&
                            (cnt_q == act_q.period - CNT_W'(1));
    assign busy           = (state_q != ST_IDLE);

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            pend_q     <= '0;
            act_q      <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            per_q      <= '0;
            pwm        <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_q <= '{cfg_period, cfg_high, mode_decode(cfg_mode), cfg_burst, cfg_gap};
            end
            act_q      <= act_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            pwm        <= pwm_d;
            burst_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        done_d  = 1'b0;
        // Commit only at a period boundary (or when idle) so a running period never glitches.
        act_d   = ((state_q == ST_IDLE) || wrap) ? pend_q : act_q;
        pwm_d   = enable && (state_q == ST_RUN) && (act_q.period != '0) && (cnt_q < act_q.high);
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            per_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Idle commits pending cfg on this edge, so the start decision uses it directly.
                    if ((pend_q.period != '0) && ((pend_q.mode != MODE_BURST_ONCE) || trig)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        per_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (act_q.period == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        per_d   = '0;
                    end else if (wrap) begin
                        cnt_d = '0;
                        if (act_q.mode == MODE_CONT) begin
                            // Continuous mode has no burst; keep the count clean for a later mode switch.
                            per_d = '0;
                        end else if (per_last_burst) begin
                            done_d = 1'b1;
                            per_d  = '0;
                            if (act_q.mode == MODE_BURST_ONCE) begin
                                state_d = ST_IDLE;
                            end else if (act_q.gap != '0) begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            per_d = per_inc[BURST_W-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (act_q.period == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        per_d   = '0;
                    end else if (wrap) begin
                        cnt_d = '0;
                        if (per_last_gap) begin
                            state_d = ST_RUN;
                            per_d   = '0;
                        end else begin
                            per_d = per_inc[BURST_W-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_multi_burst.sv
// Multi-channel PWM with continuous, one-shot burst and repeating burst/gap modes.
// Latency: PWM/BurstDone registered; Enable at edge t0 gives first high at t1.
// Backpressure: none; CfgWr with an out-of-range CfgCh is dropped.
// Ports: Cfg* shared config write bus decoded by CfgCh; Enable/Trig per channel;
//        PWM/Busy/BurstDone per-channel outputs.
module pwm_multi_burst
    import pwm_multi_burst_pkg::*;
#(
    parameter  int NUM_CH  = PWM_NUM_CH,
    parameter  int CNT_W   = PWM_CNT_W,
    parameter  int BURST_W = PWM_BURST_W,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               SysClk,
    input  logic               Reset,
    input  logic               CfgWr,
    input  logic [CH_W-1:0]    CfgCh,
    input  logic [CNT_W-1:0]   CfgPeriod,
    input  logic [CNT_W-1:0]   CfgHigh,
    input  logic [1:0]         CfgMode,
    input  logic [BURST_W-1:0] CfgBurst,
    input  logic [BURST_W-1:0] CfgGap,
    input  logic [NUM_CH-1:0]  Enable,
    input  logic [NUM_CH-1:0]  Trig,
    output logic [NUM_CH-1:0]  PWM,
    output logic [NUM_CH-1:0]  Busy,
    output logic [NUM_CH-1:0]  BurstDone
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_multi_burst_chan #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_chan (
            .SysClk     (SysClk),
            .Reset      (Reset),
            .cfg_wr     (CfgWr && (int'(CfgCh) == i)),
            .cfg_period (CfgPeriod),
            .cfg_high   (CfgHigh),
            .cfg_mode   (CfgMode),
            .cfg_burst  (CfgBurst),
            .cfg_gap    (CfgGap),
            .enable     (Enable[i]),
            .trig       (Trig[i]),
            .pwm        (PWM[i]),
            .busy       (Busy[i]),
            .burst_done (BurstDone[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_burst.sv
module tb_pwm_multi_burst;

    localparam int NUM_CH = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_GAP  = 2;

    logic        SysClk, Reset, CfgWr;
    logic [1:0]  CfgCh, CfgMode;
    logic [15:0] CfgPeriod, CfgHigh;
    logic [7:0]  CfgBurst, CfgGap;
    logic [3:0]  Enable, Trig, PWM, Busy, BurstDone;

    pwm_multi_burst #(.NUM_CH(4), .CNT_W(16), .BURST_W(8)) dut (
        .SysClk(SysClk), .Reset(Reset), .CfgWr(CfgWr), .CfgCh(CfgCh),
        .CfgPeriod(CfgPeriod), .CfgHigh(CfgHigh), .CfgMode(CfgMode),
        .CfgBurst(CfgBurst), .CfgGap(CfgGap), .Enable(Enable), .Trig(Trig),
        .PWM(PWM), .Busy(Busy), .BurstDone(BurstDone)
    );

    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    // Reference model: per channel, cycles elapsed in the current RUN/GAP phase.
    typedef struct { int period; int high; int mode; int burst; int gap; } mcfg_t;
    mcfg_t      m_act[NUM_CH], m_pend[NUM_CH];
    int         m_st[NUM_CH], m_k[NUM_CH];
    logic [3:0] e_pwm, e_busy, e_done;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            mcfg_t a;
            int    p, n, blen;
            bit    bound, commit;
            a = m_act[c];
            p = a.period;
            if (Reset) begin
                m_st[c]   = M_IDLE;
                m_k[c]    = 0;
                m_act[c]  = '{0, 0, 0, 0, 0};
                m_pend[c] = '{0, 0, 0, 0, 0};
                e_pwm[c]  = 1'b0;
                e_busy[c] = 1'b0;
                e_done[c] = 1'b0;
            end else begin
                bound     = (m_st[c] != M_IDLE) && (p != 0) && ((m_k[c] % p) == p - 1);
                commit    = (m_st[c] == M_IDLE) || bound;
                e_pwm[c]  = Enable[c] && (m_st[c] == M_RUN) && (p != 0) && ((m_k[c] % p) < a.high);
                e_done[c] = 1'b0;
                blen      = (a.burst == 0) ? 1 : a.burst;
                if (!Enable[c]) begin
                    m_st[c] = M_IDLE;
                    m_k[c]  = 0;
                end else if (m_st[c] == M_IDLE) begin
                    if (m_pend[c].period != 0 && (m_pend[c].mode != 1 || Trig[c])) begin
                        m_st[c] = M_RUN;
                        m_k[c]  = 0;
                    end
                end else if (p == 0) begin
                    m_st[c] = M_IDLE;
                    m_k[c]  = 0;
                end else begin
                    m_k[c]++;
                    if (bound) begin
                        n = m_k[c] / p;
                        if (m_st[c] == M_RUN && a.mode == 0) m_k[c] = 0;
                        else m_k[c] = n * m_pend[c].period;
                        if (m_st[c] == M_RUN && a.mode != 0 && n >= blen) begin
                            e_done[c] = 1'b1;
                            if (a.mode == 1) m_st[c] = M_IDLE;
                            else if (a.gap != 0) m_st[c] = M_GAP;
                            m_k[c] = 0;
                        end else if (m_st[c] == M_GAP && n >= a.gap) begin
                            m_st[c] = M_RUN;
                            m_k[c]  = 0;
                        end
                    end
                end
                if (commit) m_act[c] = m_pend[c];
                if (CfgWr && int'(CfgCh) == c)
                    m_pend[c] = '{int'(CfgPeriod), int'(CfgHigh), (CfgMode == 2'd3) ? 0 : int'(CfgMode),
                                  int'(CfgBurst), int'(CfgGap)};
                e_busy[c] = (m_st[c] != M_IDLE);
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge SysClk);
        model_step();
        @(negedge SysClk);
        chk("model", int'({PWM, Busy, BurstDone}), int'({e_pwm, e_busy, e_done}));
    endtask

    task automatic do_reset();
        Reset = 1'b1; Enable = '0; Trig = '0; CfgWr = 1'b0;
        cycle();
        cycle();
        Reset = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int p, input int h, input int m, input int b, input int g);
        CfgWr = 1'b1; CfgCh = 2'(ch); CfgPeriod = 16'(p); CfgHigh = 16'(h);
        CfgMode = 2'(m); CfgBurst = 8'(b); CfgGap = 8'(g);
        cycle();
        CfgWr = 1'b0;
    endtask

    typedef struct {
        int period; int high; int mode; int burst; int gap; int trig;
        int cycles; int exp_high; int exp_done; int exp_busy;
    } vec_t;
    vec_t vecs[11];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int hi, dn, hi3, dn1, dn2;

    initial begin
        vecs[0]  = '{10, 3, 0, 0, 0, 0, 40, 12, 0, 1};
        vecs[1]  = '{ 5, 0, 0, 0, 0, 0, 20,  0, 0, 1};
        vecs[2]  = '{ 5, 5, 0, 0, 0, 0, 20, 19, 0, 1};
        vecs[3]  = '{ 0, 3, 0, 0, 0, 0, 20,  0, 0, 0};
        vecs[4]  = '{ 4, 2, 1, 3, 0, 1, 20,  6, 1, 0};
        vecs[5]  = '{ 4, 2, 1, 3, 0, 0, 20,  0, 0, 0};
        vecs[6]  = '{ 4, 1, 2, 2, 3, 0, 40,  4, 2, 1};
        vecs[7]  = '{ 4, 1, 2, 2, 0, 0, 16,  4, 1, 1};
        vecs[8]  = '{ 3, 1, 1, 0, 0, 1, 10,  1, 1, 0};
        vecs[9]  = '{ 6, 2, 3, 0, 0, 0, 24,  8, 0, 1};
        vecs[10] = '{ 4, 9, 0, 0, 0, 0, 12, 11, 0, 1};

        Reset = 1'b1; CfgWr = 1'b0; CfgCh = '0; CfgPeriod = '0; CfgHigh = '0;
        CfgMode = '0; CfgBurst = '0; CfgGap = '0; Enable = '0; Trig = '0;

        do_reset();
        chk("reset_pwm", int'(PWM), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_done", int'(BurstDone), 0);

        for (int v = 0; v < 11; v++) begin
            do_reset();
            write_cfg(0, vecs[v].period, vecs[v].high, vecs[v].mode, vecs[v].burst, vecs[v].gap);
            Enable = 4'b0001;
            Trig   = {3'b000, 1'(vecs[v].trig)};
            hi = 0; dn = 0;
            for (int i = 0; i < vecs[v].cycles; i++) begin
                cycle();
                Trig = '0;
                hi += int'(PWM[0]);
                dn += int'(BurstDone[0]);
            end
            chk($sformatf("vec%0d_high", v), hi, vecs[v].exp_high);
            chk($sformatf("vec%0d_done", v), dn, vecs[v].exp_done);
            chk($sformatf("vec%0d_busy", v), int'(Busy[0]), vecs[v].exp_busy);
            Enable = '0;
        end

        // High time rewritten mid-period: old duty finishes the period, new duty follows.
        do_reset();
        write_cfg(0, 10, 3, 0, 0, 0);
        Enable = 4'b0001;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin CfgWr = 1'b1; CfgCh = 2'd0; CfgHigh = 16'd7; end
            cycle();
            CfgWr = 1'b0;
            hi += int'(PWM[0]);
            if (i == 9)  chk("hrw_old_low", int'(PWM[0]), 0);
            if (i == 17) chk("hrw_new_high", int'(PWM[0]), 1);
        end
        chk("hrw_high_total", hi, 10);

        // Trig while busy ignored; trig after completion restarts.
        do_reset();
        write_cfg(0, 4, 2, 1, 3, 0);
        Enable = 4'b0001; Trig = 4'b0001;
        hi = 0; dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) Trig = 4'b0001;
            cycle();
            Trig = '0;
            hi += int'(PWM[0]);
            dn += int'(BurstDone[0]);
        end
        chk("retrig_high", hi, 6);
        chk("retrig_done", dn, 1);
        chk("retrig_busy", int'(Busy[0]), 0);
        Trig = 4'b0001; dn = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            Trig = '0;
            dn += int'(BurstDone[0]);
        end
        chk("restart_done", dn, 1);

        // Enable dropped mid-pulse: PWM low next edge, no BurstDone.
        do_reset();
        write_cfg(0, 4, 2, 1, 3, 0);
        Enable = 4'b0001; Trig = 4'b0001;
        cycle();
        Trig = '0;
        repeat (5) cycle();
        chk("endrop_pre_pwm", int'(PWM[0]), 1);
        Enable = '0;
        cycle();
        chk("endrop_pwm", int'(PWM[0]), 0);
        chk("endrop_busy", int'(Busy[0]), 0);
        dn = 0;
        repeat (10) begin cycle(); dn += int'(BurstDone[0]); end
        chk("endrop_done", dn, 0);

        // All channels with distinct configs at once, then reset mid-burst.
        do_reset();
        write_cfg(0, 10, 3, 0, 0, 0);
        write_cfg(1, 4, 2, 1, 3, 0);
        write_cfg(2, 4, 1, 2, 2, 3);
        write_cfg(3, 5, 5, 0, 0, 0);
        Enable = 4'b1111; Trig = 4'b0010;
        hi3 = 0; dn1 = 0; dn2 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            Trig = '0;
            hi3 += int'(PWM[3]);
            dn1 += int'(BurstDone[1]);
            dn2 += int'(BurstDone[2]);
        end
        chk("multi_ch3_high", hi3, 39);
        chk("multi_ch1_done", dn1, 1);
        chk("multi_ch2_done", dn2, 2);
        Reset = 1'b1;
        cycle();
        chk("rst_mid_pwm", int'(PWM), 0);
        chk("rst_mid_busy", int'(Busy), 0);
        chk("rst_mid_done", int'(BurstDone), 0);
        Reset = 1'b0;
        hi = 0;
        repeat (10) begin cycle(); hi += int'(PWM != 4'b0000) + int'(Busy != 4'b0000); end
        chk("rst_pending_lost", hi, 0);

        // Randomized traffic against the model.
        do_reset();
        Enable = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            CfgWr     = ($urandom_range(0, 5) == 0);
            CfgCh     = 2'($urandom_range(0, 3));
            CfgPeriod = 16'($urandom_range(0, 9));
            CfgHigh   = 16'($urandom_range(0, 10));
            CfgMode   = 2'($urandom_range(0, 3));
            CfgBurst  = 8'($urandom_range(0, 3));
            CfgGap    = 8'($urandom_range(0, 3));
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 39) == 0) Enable[c] = ~Enable[c];
            Trig  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            Reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        Reset = 1'b0; CfgWr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
